// File: rtl/load_store_buffer_if.sv
// Bus bundle between the issue stage / CDB and the load-store buffer, plus
// the buffer's request ports toward the memory address unit.
interface load_store_buffer_if;
  // Issue side
  logic        issue_valid;
  logic        issue_is_store;
  logic [3:0]  issue_base_tag;
  logic [31:0] issue_base_val;
  logic [3:0]  issue_data_tag;
  logic [31:0] issue_data_val;
  logic [31:0] issue_imm;
  logic        issue_ready;
  logic [3:0]  issue_tag;
  // Common data bus
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  // Address unit request ports
  logic        load1_valid;
  logic        load2_valid;
  logic [3:0]  load1_tag;
  logic [3:0]  load2_tag;
  logic [31:0] load1_addr;
  logic [31:0] load2_addr;
  logic        store1_valid;
  logic        store2_valid;
  logic [31:0] store1_addr;
  logic [31:0] store2_addr;
  logic [31:0] store1_data;
  logic [31:0] store2_data;

  // Environment side: drives issue/CDB, observes requests
  modport master (
    output issue_valid, issue_is_store, issue_base_tag, issue_base_val,
           issue_data_tag, issue_data_val, issue_imm,
           cdb_valid, cdb_tag, cdb_data,
    input  issue_ready, issue_tag,
           load1_valid, load2_valid, load1_tag, load2_tag, load1_addr, load2_addr,
           store1_valid, store2_valid, store1_addr, store2_addr, store1_data, store2_data
  );

  // Buffer side
  modport slave (
    input  issue_valid, issue_is_store, issue_base_tag, issue_base_val,
           issue_data_tag, issue_data_val, issue_imm,
           cdb_valid, cdb_tag, cdb_data,
    output issue_ready, issue_tag,
           load1_valid, load2_valid, load1_tag, load2_tag, load1_addr, load2_addr,
           store1_valid, store2_valid, store1_addr, store2_addr, store1_data, store2_data
  );
endinterface

// File: rtl/load_store_buffer.sv
// Two-load / two-store buffer. Entries wait on their operands via CDB snooping,
// form base+imm addresses, and present requests to the address unit while
// keeping stores in program order and holding loads behind older stores.
module load_store_buffer #(
  parameter logic [3:0] LOAD1_TAG = 4'd5,
  parameter logic [3:0] LOAD2_TAG = 4'd6
) (
  input  logic                  clk,
  input  logic                  reset,
  load_store_buffer_if.slave    bus
);

  // Load entry state
  logic [1:0]  ld_valid_r;
  logic [3:0]  ld_base_tag_r   [2];
  logic [31:0] ld_base_val_r   [2];
  logic [31:0] ld_imm_r        [2];
  logic [31:0] ld_addr_r       [2];
  logic [1:0]  ld_addr_ready_r;
  logic [1:0]  ld_mask_r       [2];

  // Store entry state
  logic [1:0]  st_valid_r;
  logic [3:0]  st_base_tag_r   [2];
  logic [31:0] st_base_val_r   [2];
  logic [3:0]  st_data_tag_r   [2];
  logic [31:0] st_data_val_r   [2];
  logic [31:0] st_imm_r        [2];
  logic [31:0] st_addr_r       [2];
  logic [1:0]  st_addr_ready_r;
  logic        st_oldest_r;

  // Decode
  logic [1:0]  ld_req_s;
  logic [1:0]  st_req_s;
  logic [1:0]  ld_perform_s;
  logic [1:0]  st_perform_s;
  logic [1:0]  st_live_s;
  logic        issue_ready_s;
  logic        ld_alloc_s;
  logic        st_alloc_s;
  logic        accept_ld_s;
  logic        accept_st_s;
  logic [3:0]  issue_tag_s;
  logic        st_oldest_nxt_s;

  function automatic logic [3:0] ld_tag_of(input logic idx);
    return idx ? LOAD2_TAG : LOAD1_TAG;
  endfunction

  // True when a pending operand tag is being broadcast on the CDB right now
  function automatic logic cdb_hit(input logic [3:0] tag, input logic cv, input logic [3:0] ct);
    return (tag != 4'd0) && cv && (ct == tag);
  endfunction

  // Request, perform, allocation and age-pointer decode from current state
  always_comb begin
    ld_req_s     = 2'b00;
    st_req_s     = 2'b00;
    ld_perform_s = 2'b00;
    for (int i = 0; i < 2; i++) begin
      ld_req_s[i]     = ld_valid_r[i] && ld_addr_ready_r[i] && (ld_mask_r[i] == 2'b00);
      st_req_s[i]     = st_valid_r[i] && st_addr_ready_r[i] && (st_data_tag_r[i] == 4'd0)
                        && (st_oldest_r == 1'(i));
      ld_perform_s[i] = ld_valid_r[i] && bus.cdb_valid && (bus.cdb_tag == ld_tag_of(1'(i)));
    end
    // The address unit serves loads first, so a store only completes on a load-free edge
    if (ld_req_s == 2'b00) begin
      st_perform_s = st_req_s;
    end else begin
      st_perform_s = 2'b00;
    end
    st_live_s     = st_valid_r & ~st_perform_s;
    issue_ready_s = bus.issue_is_store ? ~(&st_valid_r) : ~(&ld_valid_r);
    ld_alloc_s    = ld_valid_r[0];
    st_alloc_s    = st_valid_r[0];
    accept_ld_s   = bus.issue_valid && issue_ready_s && !bus.issue_is_store;
    accept_st_s   = bus.issue_valid && issue_ready_s && bus.issue_is_store;
    if (!bus.issue_is_store && issue_ready_s) begin
      issue_tag_s = ld_tag_of(ld_alloc_s);
    end else begin
      issue_tag_s = 4'd0;
    end
    // Oldest pointer follows the surviving store, or the next store to arrive
    if (accept_st_s && (st_live_s == 2'b00)) begin
      st_oldest_nxt_s = st_alloc_s;
    end else if (st_perform_s[st_oldest_r] && st_live_s[~st_oldest_r]) begin
      st_oldest_nxt_s = ~st_oldest_r;
    end else if (st_perform_s[st_oldest_r]) begin
      st_oldest_nxt_s = 1'b0;
    end else begin
      st_oldest_nxt_s = st_oldest_r;
    end
  end

  // Load entries: allocate, snoop base, form address, drain store mask, free on CDB
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_valid_r      <= 2'b00;
      ld_addr_ready_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        ld_base_tag_r[i] <= 4'd0;
        ld_base_val_r[i] <= 32'd0;
        ld_imm_r[i]      <= 32'd0;
        ld_addr_r[i]     <= 32'd0;
        ld_mask_r[i]     <= 2'b00;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (accept_ld_s && (ld_alloc_s == 1'(i))) begin
          ld_valid_r[i]      <= 1'b1;
          ld_addr_ready_r[i] <= 1'b0;
          ld_imm_r[i]        <= bus.issue_imm;
          ld_mask_r[i]       <= st_live_s;
          if (cdb_hit(bus.issue_base_tag, bus.cdb_valid, bus.cdb_tag)) begin
            ld_base_tag_r[i] <= 4'd0;
            ld_base_val_r[i] <= bus.cdb_data;
          end else begin
            ld_base_tag_r[i] <= bus.issue_base_tag;
            ld_base_val_r[i] <= bus.issue_base_val;
          end
        end else if (ld_valid_r[i]) begin
          ld_mask_r[i] <= ld_mask_r[i] & ~st_perform_s;
          if (cdb_hit(ld_base_tag_r[i], bus.cdb_valid, bus.cdb_tag)) begin
            ld_base_tag_r[i] <= 4'd0;
            ld_base_val_r[i] <= bus.cdb_data;
          end
          if ((ld_base_tag_r[i] == 4'd0) && !ld_addr_ready_r[i]) begin
            ld_addr_r[i]       <= ld_base_val_r[i] + ld_imm_r[i];
            ld_addr_ready_r[i] <= 1'b1;
          end
          if (ld_perform_s[i]) begin
            ld_valid_r[i]      <= 1'b0;
            ld_addr_ready_r[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Store entries: allocate, snoop base and data, form address, free when performed
  always_ff @(posedge clk) begin
    if (reset) begin
      st_valid_r      <= 2'b00;
      st_addr_ready_r <= 2'b00;
      st_oldest_r     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        st_base_tag_r[i] <= 4'd0;
        st_base_val_r[i] <= 32'd0;
        st_data_tag_r[i] <= 4'd0;
        st_data_val_r[i] <= 32'd0;
        st_imm_r[i]      <= 32'd0;
        st_addr_r[i]     <= 32'd0;
      end
    end else begin
      st_oldest_r <= st_oldest_nxt_s;
      for (int i = 0; i < 2; i++) begin
        if (accept_st_s && (st_alloc_s == 1'(i))) begin
          st_valid_r[i]      <= 1'b1;
          st_addr_ready_r[i] <= 1'b0;
          st_imm_r[i]        <= bus.issue_imm;
          if (cdb_hit(bus.issue_base_tag, bus.cdb_valid, bus.cdb_tag)) begin
            st_base_tag_r[i] <= 4'd0;
            st_base_val_r[i] <= bus.cdb_data;
          end else begin
            st_base_tag_r[i] <= bus.issue_base_tag;
            st_base_val_r[i] <= bus.issue_base_val;
          end
          if (cdb_hit(bus.issue_data_tag, bus.cdb_valid, bus.cdb_tag)) begin
            st_data_tag_r[i] <= 4'd0;
            st_data_val_r[i] <= bus.cdb_data;
          end else begin
            st_data_tag_r[i] <= bus.issue_data_tag;
            st_data_val_r[i] <= bus.issue_data_val;
          end
        end else if (st_valid_r[i]) begin
          if (cdb_hit(st_base_tag_r[i], bus.cdb_valid, bus.cdb_tag)) begin
            st_base_tag_r[i] <= 4'd0;
            st_base_val_r[i] <= bus.cdb_data;
          end
          if (cdb_hit(st_data_tag_r[i], bus.cdb_valid, bus.cdb_tag)) begin
            st_data_tag_r[i] <= 4'd0;
            st_data_val_r[i] <= bus.cdb_data;
          end
          if ((st_base_tag_r[i] == 4'd0) && !st_addr_ready_r[i]) begin
            st_addr_r[i]       <= st_base_val_r[i] + st_imm_r[i];
            st_addr_ready_r[i] <= 1'b1;
          end
          if (st_perform_s[i]) begin
            st_valid_r[i]      <= 1'b0;
            st_addr_ready_r[i] <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.issue_ready  = issue_ready_s;
  assign bus.issue_tag    = issue_tag_s;
  assign bus.load1_valid  = ld_req_s[0];
  assign bus.load2_valid  = ld_req_s[1];
  assign bus.load1_tag    = LOAD1_TAG;
  assign bus.load2_tag    = LOAD2_TAG;
  assign bus.load1_addr   = ld_addr_r[0];
  assign bus.load2_addr   = ld_addr_r[1];
  assign bus.store1_valid = st_req_s[0];
  assign bus.store2_valid = st_req_s[1];
  assign bus.store1_addr  = st_addr_r[0];
  assign bus.store2_addr  = st_addr_r[1];
  assign bus.store1_data  = st_data_val_r[0];
  assign bus.store2_data  = st_data_val_r[1];

endmodule

// File: doc/load_store_buffer.md
Name: load_store_buffer

Overview:
- Holds 2 load entries and 2 store entries between the issue stage and the memory address unit.
- Each entry waits on its base register, and stores also on their data operand, by snooping the CDB. It then forms the effective address base+imm.
- It drives the address unit's load1/load2/store1/store2 request ports.
- It enforces memory ordering: stores perform in program order, and a load performs only after every store that was older at its issue has performed.

Parameters:
- LOAD1_TAG, 4'd5, CDB tag owned by load entry 1.
- LOAD2_TAG, 4'd6, CDB tag owned by load entry 2.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous active-high reset
- issue_valid  in  1  new memory op offered this cycle
- issue_is_store  in  1  1=store, 0=load
- issue_base_tag  in  4  producer tag of base; 0 = value ready
- issue_base_val  in  32  base value when tag==0
- issue_data_tag  in  4  producer tag of store data; 0 = ready
- issue_data_val  in  32  store data when tag==0
- issue_imm  in  32  sign-extended offset
- issue_ready  out  1  a free entry of the requested kind exists (combinational on issue_is_store)
- issue_tag  out  4  tag assigned to the accepted load (LOAD1_TAG/LOAD2_TAG); 0 for stores
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  4  CDB tag
- cdb_data  in  32  CDB value
- load1_valid, load2_valid  out  1  load request to address unit
- load1_tag, load2_tag  out  4  constant LOAD1_TAG / LOAD2_TAG
- load1_addr, load2_addr  out  32  effective address
- store1_valid, store2_valid  out  1  store request
- store1_addr, store2_addr  out  32  effective address
- store1_data, store2_data  out  32  store data

Behaviour:
- Reset: all entry valid bits cleared; all *_valid outputs 0; issue_ready 1; store age pointer cleared to entry 1; addresses/data 0.
- Accept: issue_valid && issue_ready at posedge. The lowest-numbered free entry of that kind is written.
- Operand capture: an operand with tag!=0 is captured when cdb_valid && cdb_tag==tag. The operand then becomes ready with tag 0.
- Issue-cycle bypass: if the CDB matches an incoming operand tag in the accept cycle, cdb_data is stored and the operand is marked ready.
- Address: 32-bit wrap-around add, base+imm. It is registered the cycle after the base becomes ready, so addr_ready lags base-ready by 1 cycle.
- Load ordering mask: at accept, the load records a 2-bit mask of the currently valid store entries. A mask bit clears when that store performs.
- Load request: loadN_valid = entry valid && addr_ready && mask==0.
- Store request: storeN_valid = entry valid && addr_ready && data ready && entry is the oldest store (age pointer).
- Store performed: at a posedge where storeN_valid=1 and no load*_valid=1, since the address unit prioritises loads. That store's entry is freed and its bit cleared from every load mask. The age pointer moves to the other store entry if it is valid; otherwise it points at the next store accepted.
- Load performed: cdb_valid && cdb_tag==loadN_tag. The entry is freed at that edge and loadN_valid is 0 next cycle. The entry stays requesting until then.
- Free/accept same cycle: an entry freed at edge E is reusable only from edge E+1. issue_ready reflects occupancy before the edge.
- Stores never forward to loads; no address comparison is done (conservative ordering).
- Reset mid-operation discards all entries; the address unit sees all requests drop the next cycle.

Test Plan:
- Load, base ready: base_val=0x100, imm=4 -> issue_tag=5. load1_valid=1 with addr=0x104 two cycles after accept. CDB tag 5 -> load1_valid=0 next cycle.
- Waiting operand: store with base_tag=3, data ready 0xAA, imm=8. CDB tag3 data 0x200 -> store1_valid next+1 cycle with addr=0x208, data=0xAA. It is freed at the first edge where no load is valid.
- Ordering: store S (base pending) accepted, then load L (ready) -> L held (load1_valid=0) until S performs, then load1_valid=1 the next cycle.
- Store program order: store A (data pending), then store B (ready) -> store2_valid stays 0 until A performs.
- Full: two loads accepted -> issue_ready=0 for a load and 1 for a store. A CDB free of tag 6 -> issue_ready=1 next cycle.
- Bypass and reset: accept a load with base_tag=7 while the CDB broadcasts tag7=0x40 -> base captured. Assert reset the next cycle -> all outputs 0 and issue_ready=1.
